// File: rtl/if_pc_gen_pkg.sv
// Shared CPU constants for the fetch PC generator: reset vector,
// sequential increment and the PC-generator state encoding.
package if_pc_gen_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    // Two-state PC generator: IDLE, or holding a predicted target
    // until the delay slot of the predicted branch has been fetched.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_WAIT_DS = 1'b1;

endpackage

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator. Selects the next fetch address from
// flush / branch-correction / stall / parked prediction / BPU / sequential,
// with a one-cycle redirect latency.
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        pred_taken,
    input  logic        pred_dely,
    input  logic [31:0] pred_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        pc_adel,
    output logic        pend_valid
);

    logic [31:0] r_pc;
    logic [0:0]  r_state;
    logic [31:0] r_pend_target;
    logic        r_pc_valid;

    logic [31:0] w_pc_nxt;
    logic [0:0]  w_state_nxt;
    logic [31:0] w_pend_nxt;

    // Next-state selection; the if/else chain order is the redirect priority.
    always_comb begin
        w_pc_nxt    = r_pc + PC_INC;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_target;
        if (flush) begin
            // Exception/eret wins over everything, parked target is dropped.
            w_pc_nxt    = flush_pc;
            w_state_nxt = ST_IDLE;
            w_pend_nxt  = '0;
        end else if (br_redirect) begin
            w_pc_nxt    = br_target;
            w_state_nxt = ST_IDLE;
        end else if (stallreq) begin
            w_pc_nxt    = r_pc;
        end else if (r_state == ST_WAIT_DS) begin
            // Delay slot was fetched last cycle; now go to the parked target.
            w_pc_nxt    = r_pend_target;
            w_state_nxt = ST_IDLE;
        end else if (pred_taken && !pred_dely) begin
            // Target itself is fetched this cycle through the BPU address
            // path, so the registered PC skips ahead to the word after it.
            w_pc_nxt    = pred_target + PC_INC;
        end else if (pred_taken && pred_dely) begin
            // Delay slot still to fetch: park the target and keep going.
            w_pend_nxt  = pred_target;
            w_state_nxt = ST_WAIT_DS;
        end
    end

    // PC, state and parked target registers; reset aborts any parked target.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc          <= RESET_PC;
            r_state       <= ST_IDLE;
            r_pend_target <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_state       <= w_state_nxt;
            r_pend_target <= w_pend_nxt;
        end
    end

    // Request becomes legal from the first clock edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_pc_valid <= 1'b0;
        else         r_pc_valid <= 1'b1;
    end

    assign pc         = r_pc;
    assign pc_valid   = r_pc_valid;
    assign pc_adel    = (r_pc[1:0] != 2'b00);
    assign pend_valid = (r_state == ST_WAIT_DS);

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: reset, BPU prediction, delay-slot parking,
// redirect priority, wrap-around and misaligned targets.
module tb_if_pc_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq, flush, br_redirect, pred_taken, pred_dely;
    logic [31:0] flush_pc, br_target, pred_target;
    logic [31:0] pc;
    logic        pc_valid, pc_adel, pend_valid;

    int n_cmp = 0;
    int n_err = 0;

    if_pc_gen #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .resetn(resetn), .stallreq(stallreq), .flush(flush),
        .flush_pc(flush_pc), .br_redirect(br_redirect), .br_target(br_target),
        .pred_taken(pred_taken), .pred_dely(pred_dely), .pred_target(pred_target),
        .pc(pc), .pc_valid(pc_valid), .pc_adel(pc_adel), .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq = 0; flush = 0; br_redirect = 0; pred_taken = 0; pred_dely = 0;
        flush_pc = '0; br_target = '0; pred_target = '0;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        idle_inputs();
        br_redirect = 1; br_target = a;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        #12;
        n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL rst_pc: got %h want bfc00000", pc); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL rst_pend: got %b want 0", pend_valid); end
        n_cmp++; if (pc_adel !== 1'b0) begin n_err++; $display("FAIL rst_adel: got %b want 0", pc_adel); end
        @(negedge clk);
        resetn = 1;
        #1;
        n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL rel_pc0: got %h want bfc00000", pc); end
        tick();
        n_cmp++; if (pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL rel_pc1: got %h want bfc00004", pc); end
        n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid: got %b want 1", pc_valid); end
        tick();
        n_cmp++; if (pc !== 32'hBFC0_0008) begin n_err++; $display("FAIL rel_pc2: got %h want bfc00008", pc); end
    endtask

    task automatic test_pred_nodelay();
        goto_pc(32'h8000_1000);
        n_cmp++; if (pc !== 32'h8000_1000) begin n_err++; $display("FAIL br_setup: got %h want 80001000", pc); end
        pred_taken = 1; pred_dely = 0; pred_target = 32'h8000_2000;
        tick();
        idle_inputs();
        n_cmp++; if (pc !== 32'h8000_2004) begin n_err++; $display("FAIL pred_nd_pc: got %h want 80002004", pc); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL pred_nd_pend: got %b want 0", pend_valid); end
    endtask

    task automatic test_ds_park();
        goto_pc(32'h8000_1000);
        pred_taken = 1; pred_dely = 1; pred_target = 32'h8000_3000;
        tick();
        n_cmp++; if (pc !== 32'h8000_1004) begin n_err++; $display("FAIL park_pc: got %h want 80001004", pc); end
        n_cmp++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL park_pend: got %b want 1", pend_valid); end
        // Stalled: BPU inputs present but must be ignored.
        stallreq = 1; pred_taken = 1; pred_dely = 0; pred_target = 32'h1234_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (pc !== 32'h8000_1004) begin n_err++; $display("FAIL stall_pc%0d: got %h want 80001004", i, pc); end
            n_cmp++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL stall_pend%0d: got %b want 1", i, pend_valid); end
        end
        // Release: parked target wins over the still-asserted prediction.
        stallreq = 0;
        tick();
        n_cmp++; if (pc !== 32'h8000_3000) begin n_err++; $display("FAIL release_pc: got %h want 80003000", pc); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL release_pend: got %b want 0", pend_valid); end
        idle_inputs();
        tick();
        n_cmp++; if (pc !== 32'h8000_3004) begin n_err++; $display("FAIL after_rel_pc: got %h want 80003004", pc); end
    endtask

    task automatic test_simultaneous();
        goto_pc(32'h8000_1000);
        pred_taken = 1; pred_dely = 1; pred_target = 32'h8000_5000;
        tick();
        idle_inputs();
        stallreq = 1; br_redirect = 1; br_target = 32'h8000_4000;
        flush = 1; flush_pc = 32'hBFC0_0380;
        tick();
        n_cmp++; if (pc !== 32'hBFC0_0380) begin n_err++; $display("FAIL simul_pc: got %h want bfc00380", pc); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL simul_pend: got %b want 0", pend_valid); end
        idle_inputs();
        tick();
        n_cmp++; if (pc !== 32'hBFC0_0384) begin n_err++; $display("FAIL simul_after: got %h want bfc00384", pc); end
        // Branch correction overrides a stall.
        stallreq = 1; br_redirect = 1; br_target = 32'h8000_4000;
        tick();
        n_cmp++; if (pc !== 32'h8000_4000) begin n_err++; $display("FAIL br_over_stall: got %h want 80004000", pc); end
        idle_inputs();
    endtask

    task automatic test_wrap_misalign();
        goto_pc(32'hFFFF_FFFC);
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_load: got %h want fffffffc", pc); end
        tick();
        n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_seq: got %h want 00000000", pc); end
        pred_taken = 1; pred_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pred: got %h want 00000000", pc); end
        flush = 1; flush_pc = 32'h8000_0002;
        tick();
        idle_inputs();
        n_cmp++; if (pc !== 32'h8000_0002) begin n_err++; $display("FAIL misal_pc: got %h want 80000002", pc); end
        n_cmp++; if (pc_adel !== 1'b1) begin n_err++; $display("FAIL misal_adel: got %b want 1", pc_adel); end
        tick();
        n_cmp++; if (pc !== 32'h8000_0006) begin n_err++; $display("FAIL misal_seq: got %h want 80000006", pc); end
        goto_pc(32'h8000_0008);
        n_cmp++; if (pc_adel !== 1'b0) begin n_err++; $display("FAIL align_adel: got %b want 0", pc_adel); end
    endtask

    task automatic test_reset_abort();
        goto_pc(32'h8000_1000);
        pred_taken = 1; pred_dely = 1; pred_target = 32'h8000_7000;
        tick();
        idle_inputs();
        n_cmp++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL abort_setup: got %b want 1", pend_valid); end
        #2 resetn = 0;
        #1;
        n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL abort_pc: got %h want bfc00000", pc); end
        n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL abort_pend: got %b want 0", pend_valid); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", pc_valid); end
        @(negedge clk);
        resetn = 1;
        tick();
        n_cmp++; if (pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL abort_after: got %h want bfc00004", pc); end
    endtask

    initial begin
        test_reset();
        test_pred_nodelay();
        test_ds_park();
        test_simultaneous();
        test_wrap_misalign();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
